// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_arbiter
//  Purpose  : Arbitrates a single-ported RAM between an instruction fetch
//             port and a data read/write port. Ties alternate between the two
//             sides. A wait counter and the RAM error status send the arbiter
//             into a sticky FAULT state that only reset clears.
//  Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int TIMEOUT = 64  // legal 1..255
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction fetch port
  input  logic        iREN,
  input  logic [31:0] iaddr,
  // data port
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  // completion and returned data
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // sticky fault flag
  output logic        err
);

  // RAM status encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3. Only the two
  // values that change control flow are named here; FREE and BUSY both mean
  // "keep waiting".
  localparam logic [1:0] C_RAM_ACCESS = 2'd2;
  localparam logic [1:0] C_RAM_ERROR  = 2'd3;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  // Which side was served most recently; reset value lets data win the first tie.
  localparam logic C_GRANT_INSTR = 1'b0;
  localparam logic C_GRANT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DSERV = 3'd1,
    S_ISERV = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_inc;
  logic        r_last_grant;
  logic [31:0] r_iload;
  logic [31:0] r_dload;

  logic        w_data_req;
  logic        w_in_service;
  logic        w_access;
  logic        w_ram_error;
  logic        w_timeout;

  assign w_data_req   = dREN | dWEN;
  assign w_in_service = (r_state == S_DSERV) || (r_state == S_ISERV);
  assign w_access     = (ramstate == C_RAM_ACCESS);
  assign w_ram_error  = (ramstate == C_RAM_ERROR);

  // The counter holds the number of finished waiting cycles; the fault fires
  // in the waiting cycle that would bring it up to TIMEOUT, so the transaction
  // gets exactly TIMEOUT service cycles to see ACCESS.
  assign w_wait_inc = r_wait_cnt + 8'd1;
  assign w_timeout  = (w_wait_inc == C_TIMEOUT) && !w_access;

  assign iload = r_iload;
  assign dload = r_dload;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection plus all RAM strobes, hits and the fault flag.
  always_comb begin
    w_next_state = r_state;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'd0;
    ramstore     = 32'd0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    err          = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Data goes first unless both are waiting and data was served last.
        if (w_data_req && (!iREN || (r_last_grant == C_GRANT_INSTR))) begin
          w_next_state = S_DSERV;
        end else if (iREN) begin
          w_next_state = S_ISERV;
        end
      end

      S_DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;  // a simultaneous write takes priority
        if (w_ram_error) begin
          w_next_state = S_FAULT;
        end else if (w_access) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          w_next_state = S_FAULT;
        end
      end

      S_ISERV: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (w_ram_error) begin
          w_next_state = S_FAULT;
        end else if (w_access) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          w_next_state = S_FAULT;
        end
      end

      S_DONE: begin
        // last_grant was updated on ACCESS, so it names the side just served.
        ihit         = (r_last_grant == C_GRANT_INSTR);
        dhit         = (r_last_grant == C_GRANT_DATA);
        w_next_state = S_IDLE;
      end

      S_FAULT: begin
        err          = 1'b1;
        w_next_state = S_FAULT;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Wait counter, grant history and captured load data.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wait_cnt   <= 8'd0;
      r_last_grant <= C_GRANT_INSTR;
      r_iload      <= 32'd0;
      r_dload      <= 32'd0;
    end else begin
      // Cleared while idle so every new service starts from zero.
      if (r_state == S_IDLE) begin
        r_wait_cnt <= 8'd0;
      end else if (w_in_service && !w_access) begin
        r_wait_cnt <= w_wait_inc;
      end

      if ((r_state == S_DSERV) && w_access) begin
        r_dload      <= dWEN ? 32'd0 : ramload;
        r_last_grant <= C_GRANT_DATA;
      end

      if ((r_state == S_ISERV) && w_access) begin
        r_iload      <= ramload;
        r_last_grant <= C_GRANT_INSTR;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_arbiter
//  Purpose  : Self-checking bench for memory_arbiter. Expected hits are queued
//             when a RAM ACCESS is driven and checked when a hit appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  localparam logic [1:0] C_FREE   = 2'd0;
  localparam logic [1:0] C_BUSY   = 2'd1;
  localparam logic [1:0] C_ACCESS = 2'd2;
  localparam logic [1:0] C_ERROR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  memory_arbiter #(.TIMEOUT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .dhit     (dhit),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every hit must match the oldest queued expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (ihit || dhit) begin
      check("hit_exclusive", {31'd0, ihit & dhit}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_hit", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("hit_side", {31'd0, dhit}, {31'd0, e.is_data});
        check("hit_load", dhit ? dload : iload, e.data);
      end
    end
  end

  // Hold reset for two edges, check every output, release at a negedge.
  task automatic do_reset();
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = C_FREE;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_ihit",     {31'd0, ihit},   32'd0);
    check("rst_dhit",     {31'd0, dhit},   32'd0);
    check("rst_err",      {31'd0, err},    32'd0);
    check("rst_ramREN",   {31'd0, ramREN}, 32'd0);
    check("rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
    check("rst_ramaddr",  ramaddr,  32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iload",    iload,    32'd0);
    check("rst_dload",    dload,    32'd0);
    nRST = 1'b1;
  endtask

  // Caller has driven the request at an IDLE negedge. Checks service strobes
  // for busy+1 cycles, drives ACCESS on the last one, then checks DONE.
  task automatic serve(input logic is_data, input logic wr, input logic [31:0] addr,
                       input logic [31:0] store, input logic [31:0] load,
                       input int busy, input logic drop);
    ramstate = C_BUSY;
    for (int i = 0; i <= busy; i++) begin
      @(negedge CLK);
      check("svc_ramREN",  {31'd0, ramREN}, is_data ? {31'd0, ~wr} : 32'd1);
      check("svc_ramWEN",  {31'd0, ramWEN}, is_data ? {31'd0, wr}  : 32'd0);
      check("svc_ramaddr", ramaddr, addr);
      if (is_data) check("svc_ramstore", ramstore, store);
      check("svc_nohit", {30'd0, ihit, dhit}, 32'd0);
      check("svc_err",   {31'd0, err}, 32'd0);
      if (i == busy) begin
        ramstate = C_ACCESS;
        ramload  = load;
        sb.push_back('{is_data: is_data, data: (is_data && wr) ? 32'd0 : load});
      end
    end
    @(negedge CLK);
    check("done_ihit",    {31'd0, ihit}, {31'd0, ~is_data});
    check("done_dhit",    {31'd0, dhit}, {31'd0, is_data});
    check("done_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("done_ramaddr", ramaddr, 32'd0);
    check("done_ramstore", ramstore, 32'd0);
    ramstate = C_FREE;
    if (drop) begin
      if (is_data) begin dREN = 1'b0; dWEN = 1'b0; end
      else iREN = 1'b0;
    end
  endtask

  // One IDLE cycle after DONE: no hits and no strobes.
  task automatic idle_gap();
    @(negedge CLK);
    check("gap_hits",    {30'd0, ihit, dhit}, 32'd0);
    check("gap_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
  endtask

  initial begin
    do_reset();

    // Single fetch, ACCESS on the third service cycle
    iREN = 1'b1; iaddr = 32'h40;
    serve(1'b0, 1'b0, 32'h40, 32'd0, 32'h8C220004, 2, 1'b1);
    idle_gap();

    // Data read at minimum latency
    dREN = 1'b1; daddr = 32'h104;
    serve(1'b1, 1'b0, 32'h104, 32'd0, 32'hCAFEF00D, 0, 1'b1);
    idle_gap();

    // Write: load register must capture 0
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    serve(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h12345678, 1, 1'b1);
    idle_gap();

    // Read and write together: write wins
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h108; dstore = 32'h0BADC0DE;
    serve(1'b1, 1'b1, 32'h108, 32'h0BADC0DE, 32'h77777777, 0, 1'b1);
    idle_gap();
    check("sb_empty_basic", sb.size(), 32'd0);

    // Contention held from the first cycle after reset: D, I, D
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h500; daddr = 32'h600;
    serve(1'b1, 1'b0, 32'h600, 32'd0, 32'h11111111, 0, 1'b0);
    idle_gap();
    serve(1'b0, 1'b0, 32'h500, 32'd0, 32'h22222222, 1, 1'b0);
    idle_gap();
    serve(1'b1, 1'b0, 32'h600, 32'd0, 32'h33333333, 0, 1'b1);
    iREN = 1'b0;
    idle_gap();
    check("sb_empty_contention", sb.size(), 32'd0);

    // Reset in the middle of a write: no hit may follow
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h000055AA; ramstate = C_BUSY;
    @(negedge CLK);
    check("mid_ramWEN_before", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    check("mid_ramWEN_after", {31'd0, ramWEN}, 32'd0);
    check("mid_ramaddr_after", ramaddr, 32'd0);
    nRST = 1'b1; dWEN = 1'b0; ramstate = C_ACCESS; ramload = 32'h00000BAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("mid_no_dhit", {31'd0, dhit}, 32'd0);
    end
    ramstate = C_FREE;

    // RAM error during data service, then a one-cycle reset and a fetch
    dREN = 1'b1; daddr = 32'h300; ramstate = C_BUSY;
    @(negedge CLK);
    check("rerr_ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = C_ERROR;
    @(negedge CLK);
    check("rerr_err",     {31'd0, err}, 32'd1);
    check("rerr_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rerr_nohit",   {30'd0, ihit, dhit}, 32'd0);
    dREN = 1'b0; ramstate = C_FREE;
    @(negedge CLK);
    check("rerr_sticky", {31'd0, err}, 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    check("rerr_cleared", {31'd0, err}, 32'd0);
    nRST = 1'b1; iREN = 1'b1; iaddr = 32'h44;
    serve(1'b0, 1'b0, 32'h44, 32'd0, 32'hA5A5F00F, 1, 1'b1);
    idle_gap();
    check("sb_empty_rerr", sb.size(), 32'd0);

    // Timeout: BUSY forever, fault visible after 4 service cycles
    do_reset();
    iREN = 1'b1; iaddr = 32'h80; ramstate = C_BUSY;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      check("tmo_err_low",  {31'd0, err}, 32'd0);
      check("tmo_ramREN",   {31'd0, ramREN}, 32'd1);
      check("tmo_ramaddr",  ramaddr, 32'h80);
    end
    @(negedge CLK);
    check("tmo_err_high", {31'd0, err}, 32'd1);
    check("tmo_strobes",  {30'd0, ramREN, ramWEN}, 32'd0);
    check("tmo_ramaddr0", ramaddr, 32'd0);
    check("tmo_noihit",   {31'd0, ihit}, 32'd0);
    iREN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("tmo_sticky", {31'd0, err}, 32'd1);
    end
    do_reset();
    check("sb_empty_final", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
Parameters:
REQ-001 SHALL define TIMEOUT, default 64 (legal 1..255): maximum cycles a RAM transaction may remain unfinished before the error state.

Ports, all single-bit unless stated:
REQ-002 SHALL have CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have nRST, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have iREN, input, 1: instruction fetch request.
REQ-005 SHALL have iaddr, input, word_t: fetch address.
REQ-006 SHALL have dREN, input, 1: data read request.
REQ-007 SHALL have dWEN, input, 1: data write request.
REQ-008 SHALL have daddr, input, word_t: data address.
REQ-009 SHALL have dstore, input, word_t: write data.
REQ-010 SHALL have ihit, output, 1: one-cycle fetch-complete pulse.
REQ-011 SHALL have dhit, output, 1: one-cycle data-complete pulse.
REQ-012 SHALL have iload, output, word_t: fetched instruction, valid while ihit=1.
REQ-013 SHALL have dload, output, word_t: read data, valid while dhit=1.
REQ-014 SHALL have ramREN, output, 1: RAM read strobe.
REQ-015 SHALL have ramWEN, output, 1: RAM write strobe.
REQ-016 SHALL have ramaddr, output, word_t: RAM address.
REQ-017 SHALL have ramstore, output, word_t: RAM write data.
REQ-018 SHALL have ramload, input, word_t: RAM read data.
REQ-019 SHALL have ramstate, input, ramstate_t: RAM status, one of FREE, BUSY, ACCESS or ERROR.
REQ-020 SHALL have err, output, 1: sticky fault flag.

Function
REQ-021 SHALL implement five states: IDLE, DSERV, ISERV, DONE and FAULT.
REQ-022 SHALL, in IDLE, drive no RAM strobe and choose the next request as follows.
- Data request only (dREN|dWEN): go to DSERV.
- iREN only: go to ISERV.
- Both pending: grant the side not served last, using a last_grant register that resets to instruction, so data wins the first tie.
REQ-023 SHALL, in DSERV, set ramaddr=daddr and ramstore=dstore, and assert ramWEN=dWEN and ramREN=dREN&~dWEN; when both dWEN and dREN are set, the write wins.
REQ-024 SHALL, in ISERV, assert ramREN=1 and ramWEN=0 and set ramaddr=iaddr.
REQ-025 SHALL, in IDLE, DONE and FAULT, drive ramaddr and ramstore to 0.
REQ-026 SHALL handle ramstate=ACCESS in DSERV or ISERV as follows.
- Capture ramload into the matching load register; writes capture 0.
- Update last_grant.
- Go to DONE.
REQ-027 SHALL, in DONE, assert exactly one of ihit or dhit for one cycle with the load register stable, then return to IDLE; no RAM strobe is driven in DONE.
REQ-028 SHALL give a latency of ACCESS-cycle+1 from a RAM ACCESS to the hit; the minimum request-to-hit time is 2 cycles when ramstate=ACCESS on the first service cycle.
REQ-029 SHALL use an 8-bit wait counter, cleared on entry to DSERV or ISERV and incremented each cycle that ramstate≠ACCESS.
REQ-030 SHALL go to FAULT when ramstate=ERROR, or when the counter equals TIMEOUT and ACCESS is absent.
REQ-031 SHALL, in FAULT, set err=1, drive no RAM strobe and no hits, and remain there until reset.
REQ-032 SHALL continue a transaction if the requester drops its request mid-service; the resulting hit may be ignored, and no transaction is ever abandoned.
REQ-033 SHALL require requesters to deassert in the cycle they observe their hit; a request still high in the following IDLE cycle is treated as a new request.
REQ-034 SHALL NOT assert ihit and dhit in the same cycle.

Reset
REQ-035 SHALL, while nRST=0 at a rising edge, reset the following on that edge, including from mid-transaction or from FAULT:
- state → IDLE, counter → 0, last_grant → instruction;
- ihit, dhit, err → 0;
- iload, dload → 0;
- all RAM outputs → 0.
REQ-036 SHALL allow a request present on the first cycle after reset release to be granted from IDLE on that cycle.

Verification
REQ-037 Bench SHALL cover single fetch: iREN=1, iaddr=0x40, ramstate=ACCESS after 2 cycles with ramload=0x8C220004 → ramREN=1, ramaddr=0x40, then ihit=1 for one cycle with iload=0x8C220004.
REQ-038 Bench SHALL cover write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF → ramWEN=1, ramstore=0xDEADBEEF; on ACCESS, dhit pulses once and ihit stays 0.
REQ-039 Bench SHALL cover contention: iREN=dREN=1 held after reset → data is served first, then instruction; hits alternate dhit then ihit with a DONE gap between them.
REQ-040 Bench SHALL cover timeout: TIMEOUT=4, iREN=1, ramstate held BUSY → err=1 exactly 4 service cycles after entering ISERV, with no ihit and strobes at 0.
REQ-041 Bench SHALL cover RAM error: ramstate=ERROR during DSERV → FAULT on the next cycle; nRST=0 for one cycle → IDLE, err=0, and a new iREN is served normally.
REQ-042 Bench SHALL cover reset mid-transaction: nRST=0 while in DSERV with dWEN=1 → ramWEN=0 on the next cycle and no dhit is ever produced for that request.
